// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state type, VIA pa bit positions and HD44780 command bytes
package lcd_pkg;
  typedef enum logic [2:0] {
    IDLE,
    BF_SETUP,
    BF_EHI,
    BF_HOLD,
    WR_SETUP,
    WR_EHI,
    WR_HOLD
  } lcd_state_t;
  localparam int PA_E  = 7;
  localparam int PA_RW = 6;
  localparam int PA_RS = 5;
  localparam logic [7:0] LCD_CLEAR        = 8'h01;
  localparam logic [7:0] LCD_ENTRY        = 8'h06;
  localparam logic [7:0] LCD_DISP_ON      = 8'h0E;
  localparam logic [7:0] LCD_FUNC_8BIT_2L = 8'h38;
endpackage

// File: rtl/lcd_bus_sequencer.sv
// lcd_bus_sequencer: busy-poll then timed write of one byte on an HD44780 bus
module lcd_bus_sequencer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC  = 4,
  parameter int E_HIGH_CYC = 25,
  parameter int HOLD_CYC   = 4,
  parameter int MAX_POLLS  = 4096
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       done,
  output logic       timeout_err,
  input  logic       err_clr,
  output logic       lcd_e,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [7:0] lcd_db_out,
  output logic       lcd_db_oe,
  input  logic [7:0] lcd_db_in
);
  localparam int CMAX = (SETUP_CYC > E_HIGH_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                                 : ((E_HIGH_CYC > HOLD_CYC) ? E_HIGH_CYC : HOLD_CYC);
  localparam int CW = $clog2(CMAX + 1);
  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam logic [CW-1:0] C_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] C_EHI   = CW'(E_HIGH_CYC - 1);
  localparam logic [CW-1:0] C_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(MAX_POLLS - 1);
  lcd_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_polls;
  logic          r_rs;
  logic [7:0]    r_data;
  logic          r_busy;
  logic          w_last;
  logic          w_unused_db;
  assign w_last      = r_cnt == '0;
  assign w_unused_db = ^lcd_db_in[6:0];
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_polls     <= '0;
      r_rs        <= 1'b0;
      r_data      <= '0;
      r_busy      <= 1'b0;
      req_ready   <= 1'b1;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      lcd_e       <= 1'b0;
      lcd_rw      <= 1'b1;
      lcd_rs      <= 1'b0;
      lcd_db_out  <= '0;
      lcd_db_oe   <= 1'b0;
    end else begin
      done  <= 1'b0;
      r_cnt <= r_cnt - 1'b1;
      if (err_clr) timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (req_valid) begin
            r_rs      <= req_rs;
            r_data    <= req_data;
            req_ready <= 1'b0;
            r_state   <= BF_SETUP;
            r_cnt     <= C_SETUP;
          end
        end
        BF_SETUP: if (w_last) begin
          lcd_e   <= 1'b1;
          r_state <= BF_EHI;
          r_cnt   <= C_EHI;
        end
        BF_EHI: if (w_last) begin
          r_busy  <= lcd_db_in[7];
          lcd_e   <= 1'b0;
          r_state <= BF_HOLD;
          r_cnt   <= C_HOLD;
        end
        BF_HOLD: if (w_last) begin
          if (!r_busy) begin
            r_polls    <= '0;
            lcd_rw     <= 1'b0;
            lcd_rs     <= r_rs;
            lcd_db_oe  <= 1'b1;
            lcd_db_out <= r_data;
            r_state    <= WR_SETUP;
            r_cnt      <= C_SETUP;
          end else if (r_polls == P_LAST) begin
            r_polls     <= '0;
            timeout_err <= 1'b1;
            req_ready   <= 1'b1;
            r_state     <= IDLE;
            r_cnt       <= '0;
          end else begin
            r_polls <= r_polls + 1'b1;
            r_state <= BF_SETUP;
            r_cnt   <= C_SETUP;
          end
        end
        WR_SETUP: if (w_last) begin
          lcd_e   <= 1'b1;
          r_state <= WR_EHI;
          r_cnt   <= C_EHI;
        end
        WR_EHI: if (w_last) begin
          lcd_e   <= 1'b0;
          r_state <= WR_HOLD;
          r_cnt   <= C_HOLD;
        end
        WR_HOLD: if (w_last) begin
          lcd_db_oe  <= 1'b0;
          lcd_db_out <= '0;
          lcd_rw     <= 1'b1;
          lcd_rs     <= 1'b0;
          done       <= 1'b1;
          req_ready  <= 1'b1;
          r_state    <= IDLE;
          r_cnt      <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/lcd_bus_sequencer.md
Name: lcd_bus_sequencer

Overview:
- Hardware sequencer for the HD44780-style character LCD on the VIA port pins: data bus on pb[7:0]; control on pa[7]=E, pa[6]=RW, pa[5]=RS.
- Takes one command/data byte at a time from the CPU-side register block and runs the full bus protocol:
  - busy-flag poll (RS=0, RW=1, read DB7);
  - then the timed write cycle.
- Removes the software busy-wait loop. Sits between the SoC register decode and the pa/pb pad muxing in top.

Parameters:
- SETUP_CYC, 4, clk cycles RS/RW/data held stable before E rises (≥60 ns at 50 MHz).
- E_HIGH_CYC, 25, clk cycles E held high (≥450 ns).
- HOLD_CYC, 4, clk cycles E low with RS/RW/data still held after E falls.
- MAX_POLLS, 4096, busy polls allowed before the request is abandoned.

Ports:
- clk  in  1  system clock (50 MHz)
- RST  in  1  synchronous active-high reset
- req_valid  in  1  byte request present
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_rs  in  1  0=command, 1=data
- req_data  in  8  byte to write
- done  out  1  one-cycle pulse when a write completes
- timeout_err  out  1  sticky; set when MAX_POLLS is exceeded
- err_clr  in  1  clears timeout_err
- lcd_e  out  1  to pa[7]
- lcd_rw  out  1  to pa[6]
- lcd_rs  out  1  to pa[5]
- lcd_db_out  out  8  to pb when lcd_db_oe=1
- lcd_db_oe  out  1  pb output enable
- lcd_db_in  in  8  pb pad input

Behaviour:
- Reset: all outputs are registered. On reset: lcd_e=0, lcd_rw=1, lcd_rs=0, lcd_db_oe=0, lcd_db_out=0, done=0, timeout_err=0, req_ready=1, state=IDLE, poll count=0. RST mid-transaction aborts at the next edge; the pending byte is dropped.
- Idle bus value: E=0, RW=1, RS=0, oe=0 (pa[7:5]=3'b010).
- Handshake: transfer occurs when req_valid & req_ready at a rising edge. req_data and req_rs are captured into holding registers. req_ready drops the next cycle.
- FSM states: IDLE → BF_SETUP → BF_EHI → BF_HOLD → (busy ? BF_SETUP : WR_SETUP) → WR_EHI → WR_HOLD → IDLE.
- BF_SETUP: SETUP_CYC cycles, RS=0, RW=1, oe=0, E=0.
- BF_EHI: E_HIGH_CYC cycles with E=1. lcd_db_in[7] is registered on the last E-high cycle.
- BF_HOLD: HOLD_CYC cycles with E=0. At its end:
  - sampled DB7=1 → poll count +1, return to BF_SETUP;
  - DB7=0 → WR_SETUP, poll count cleared.
- Timeout: if poll count reaches MAX_POLLS with DB7 still 1, then timeout_err←1, the request is dropped, go IDLE, done is not pulsed.
- WR_SETUP: SETUP_CYC cycles. RS=held rs, RW=0, oe=1, db_out=held data, E=0. oe rises in the same cycle RW falls.
- WR_EHI: E_HIGH_CYC cycles with E=1.
- WR_HOLD: HOLD_CYC cycles with E=0, oe=1, data held. On exit (entering IDLE): oe=0, RW=1, RS=0, done=1 for one cycle, req_ready=1.
- Latency with no busy: acceptance edge = cycle 0.
  - Bus phase starts cycle 1.
  - done and req_ready are high in cycle 1+2*(SETUP+E_HIGH+HOLD) = 67 at defaults.
  - Each extra busy poll adds 33 cycles.
- One cycle counter, width clog2(max(SETUP,E_HIGH,HOLD)+1); reloads on every state change.
- Poll counter width clog2(MAX_POLLS+1).
- Bus contention rule: RW=0 and oe=1 are never asserted while RW=1 is still driving the LCD with E high. Write data is driven only in WR_* states.
- err_clr together with a same-cycle timeout set: set wins.
- A req_valid held while not ready is ignored with no side effect.

Decomposition:
- Package lcd_pkg holds:
  - typedef enum lcd_state_t {IDLE, BF_SETUP, BF_EHI, BF_HOLD, WR_SETUP, WR_EHI, WR_HOLD};
  - localparams for pa bit indices E=7, RW=6, RS=5;
  - HD44780 command constants (CLEAR=8'h01, ENTRY=8'h06, DISP_ON=8'h0E, FUNC_8BIT_2L=8'h38).
- No sub-module; a single FSM with one phase counter is the natural size.

Test Plan:
- Reset, then lcd_db_in=8'h00, send rs=0, data=8'h38:
  - bus reads 3'b010 for 4 cycles, then E high for 25 cycles;
  - then RW=0, RS=0, pb=8'h38 with oe=1 for 33 cycles;
  - done pulses at cycle 67; req_ready is low from cycle 1 to cycle 66.
- lcd_db_in[7]=1 for the first 3 polls, then 0; send rs=1, data=8'h48 ('H'):
  - exactly 4 E pulses with RW=1, then one write with RS=1;
  - done at cycle 67+3*33=166.
- lcd_db_in[7] stuck at 1 with MAX_POLLS=8:
  - 8 polls, then timeout_err=1 and return to IDLE;
  - no write pulse, no done.
  - err_clr then clears timeout_err.
- Assert RST during WR_EHI:
  - next cycle E=0, RW=1, oe=0, req_ready=1;
  - a new request then completes normally.
- req_valid held high continuously with a 5-byte stream ("Hello"):
  - five done pulses;
  - pb write values 48,65,6C,6C,6F in order;
  - no accept while busy.
